player_sprite_animator: RTL
===========================

# player_sprite_animator

Parametrised successor to the single-pose player sprite addresser. It tracks the player's animation state (idle / walk cycle / jump) and facing direction across video frames. For each drawn pixel it produces a registered sprite-ROM address and an on-sprite flag. It sits between the player motion logic and the sprite ROM / colour mapper in the draw pipeline.

## Interface
Parameters:
- SPRITE_W, 48, sprite width in pixels
- SPRITE_H, 68, sprite height in pixels
- NUM_WALK_FRAMES, 6, walk-cycle length (≥2)
- FRAME_HOLD, 8, frame_tick pulses each walk frame is shown (≥1)
- MIRROR, 0, 0 = separate left-facing sheet; 1 = left derived by column flip of right sheet
- BASE_ADDR, 0, ROM address of sheet start
- ADDR_W, 21, spriteAddress width

Ports:
- frame_Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- moving  in  1  player walking
- jumping  in  1  player airborne
- playerDirection  in  1  0 = right, 1 = left
- DrawX, DrawY  in  10 each  current pixel
- PlayerX, PlayerY  in  10 each  sprite top-left
- playerOn  out  1  pixel inside sprite box (registered)
- spriteAddress  out  ADDR_W  ROM address (registered)
- animState  out  2  0 IDLE, 1 WALK, 2 JUMP
- frameIndex  out  $clog2(NUM_WALK_FRAMES+2)  current sheet frame

## Operation
- Sheet layout per direction: frame 0 = idle, 1..NUM_WALK_FRAMES = walk, NUM_WALK_FRAMES+1 = jump. FRAME_SZ = SPRITE_W*SPRITE_H.
- DIR_OFF = (NUM_WALK_FRAMES+2)*FRAME_SZ for MIRROR=0. DIR_OFF = 0 for MIRROR=1.
- State, direction and counters update only on cycles with frame_tick=1. They are otherwise held, so the whole displayed frame uses one pose.
- Next state on tick: jumping → JUMP; else moving → WALK; else IDLE.
- Entering WALK from any other state: walkIdx=0, holdCnt=0.
- In WALK, on each tick: holdCnt==FRAME_HOLD-1 → holdCnt=0 and walkIdx advances, with NUM_WALK_FRAMES-1 wrapping to 0. Otherwise holdCnt++.
- frameIndex: IDLE 0, WALK walkIdx+1, JUMP NUM_WALK_FRAMES+1.
- Direction is latched on tick.
- Hit test uses 11-bit arithmetic (no wrap): PlayerX ≤ DrawX ≤ PlayerX+SPRITE_W-1 and PlayerY ≤ DrawY ≤ PlayerY+SPRITE_H-1.
- dx = DrawX-PlayerX, dy = DrawY-PlayerY. col = dx, except col = SPRITE_W-1-dx when MIRROR=1 and direction is left.
- Address on hit: BASE_ADDR + frameIndex*FRAME_SZ + dir*DIR_OFF + dy*SPRITE_W + col.
- Address on miss: BASE_ADDR + frameIndex*FRAME_SZ + dir*DIR_OFF.

## Timing
- Reset values: playerOn 0, spriteAddress BASE_ADDR, animState IDLE, frameIndex 0, walkIdx 0, holdCnt 0, dir 0.
- Pixel path latency is 1 cycle: outputs at cycle t+1 reflect DrawX/DrawY/PlayerX/PlayerY sampled at t.
- A tick at cycle t changes animState/frameIndex at t+1. The address produced at t+1 uses the state from before the tick, and the new pose applies from t+2.
- Reset has priority over frame_tick. Reset mid-walk returns to IDLE frame 0 next cycle.
- moving and jumping both set → JUMP. jumping dropping while moving → WALK restarting at walkIdx 0.

## Structure
- Package player_anim_pkg: anim_state_t enum (IDLE, WALK, JUMP), frame-layout helper constants (FRAME_SZ, DIR_OFF functions).
- Sub-module anim_frame_sequencer: state machine, holdCnt, walkIdx, direction latch, frameIndex.
- Top level: hit test and address arithmetic only.

## Test plan
- Idle, right, PlayerX=100, PlayerY=50, Draw=(110,52) → next cycle playerOn=1, spriteAddress=106.
- Same pixel, direction left latched by tick: MIRROR=0 → 26218; MIRROR=1 → col 37, address 133.
- Box boundaries at PlayerX=100, PlayerY=50: DrawX 99/100/147/148 → playerOn 0/1/1/0; DrawY 117/118 → 1/0. PlayerX=1000 gives no wraparound hits at DrawX<1000.
- Walk sequence: moving=1 with tick pulses → frameIndex 1 after first tick, 2 after 8 more ticks, back to 1 after 48 walking ticks. Address base for frame 2 = 6528.
- Jump and reset: jumping=1 during walk → next tick frameIndex 7, base 22848. Reset asserted mid-walk → next cycle animState 0, frameIndex 0, spriteAddress 0, playerOn 0.

Source files
------------

// File: rtl/player_sprite_animator_pkg.sv
// player_anim_pkg
// Shared types and sheet-layout helpers for the player sprite animator.
//   anim_state_t : animation pose class (IDLE / WALK / JUMP), 2-bit encoded
//   frame_sz()   : pixels (ROM words) in one sprite frame
//   dir_off()    : ROM offset between the right- and left-facing sheets
package player_anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2
  } anim_state_t;

  function automatic int frame_sz(input int sprite_w, input int sprite_h);
    return sprite_w * sprite_h;
  endfunction

  // With mirroring the left pose reuses the right sheet, so no offset.
  function automatic int dir_off(input int num_walk_frames, input int sprite_w,
                                 input int sprite_h, input int mirror);
    return (mirror != 0) ? 0 : (num_walk_frames + 2) * sprite_w * sprite_h;
  endfunction

endpackage

// File: rtl/player_sprite_animator_sequencer.sv
// anim_frame_sequencer
// Per-video-frame pose tracker: animation state, walk-cycle position,
// hold counter and facing-direction latch. Everything advances only on
// frame_tick so a whole displayed frame uses one pose.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   frame_tick        : one-cycle pulse per video frame
//   moving, jumping   : player motion flags (jumping wins)
//   direction         : 0 = right, 1 = left, latched on tick
//   state             : current animation state (also the FSM debug view)
//   frame_index       : sheet frame number for the current pose
//   dir               : latched facing direction
module anim_frame_sequencer
  import player_anim_pkg::*;
#(
  parameter int NUM_WALK_FRAMES = 6,
  parameter int FRAME_HOLD      = 8,
  localparam int FI_W           = $clog2(NUM_WALK_FRAMES + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              moving,
  input  logic              jumping,
  input  logic              direction,
  output anim_state_t       state,
  output logic [FI_W-1:0]   frame_index,
  output logic              dir
);

  localparam int WIDX_W = $clog2(NUM_WALK_FRAMES);
  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  anim_state_t       state_q, state_d;
  logic [WIDX_W-1:0] walk_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              dir_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset)           state_q <= IDLE;
    else if (frame_tick) state_q <= state_d;
  end

  // Next-state logic: the pose is purely a function of the motion flags
  always_comb begin
    state_d = IDLE;
    if (jumping)     state_d = JUMP;
    else if (moving) state_d = WALK;
  end

  // Walk-cycle counters and direction latch
  always_ff @(posedge clk) begin
    if (reset) begin
      walk_idx <= '0;
      hold_cnt <= '0;
      dir_q    <= 1'b0;
    end else if (frame_tick) begin
      dir_q <= direction;
      if (state_d == WALK) begin
        if (state_q != WALK) begin
          // Entering the walk always restarts the cycle from its first frame.
          walk_idx <= '0;
          hold_cnt <= '0;
        end else if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
          hold_cnt <= '0;
          walk_idx <= (walk_idx == WIDX_W'(NUM_WALK_FRAMES - 1)) ? '0
                                                                 : walk_idx + WIDX_W'(1);
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

  // Output logic
  always_comb begin
    frame_index = '0;
    case (state_q)
      IDLE:    frame_index = '0;
      WALK:    frame_index = FI_W'(walk_idx) + FI_W'(1);
      JUMP:    frame_index = FI_W'(NUM_WALK_FRAMES + 1);
      default: frame_index = '0;
    endcase
  end

  assign state = state_q;
  assign dir   = dir_q;

endmodule

// File: rtl/player_sprite_animator.sv
// player_sprite_animator
// Animated player sprite addresser. Tracks the pose via anim_frame_sequencer
// and, per drawn pixel, registers a sprite-ROM address and on-sprite flag.
// Ports:
//   frame_Clk, Reset        : pixel clock, synchronous active-high reset
//   frame_tick              : one-cycle pulse per video frame
//   moving, jumping         : motion flags from the player logic
//   playerDirection         : 0 = right, 1 = left
//   DrawX, DrawY            : current pixel
//   PlayerX, PlayerY        : sprite top-left
//   playerOn                : pixel inside sprite box (registered)
//   spriteAddress           : sprite ROM address (registered)
//   animState               : 0 IDLE, 1 WALK, 2 JUMP
//   frameIndex              : current sheet frame
module player_sprite_animator
  import player_anim_pkg::*;
#(
  parameter int SPRITE_W        = 48,
  parameter int SPRITE_H        = 68,
  parameter int NUM_WALK_FRAMES = 6,
  parameter int FRAME_HOLD      = 8,
  parameter int MIRROR          = 0,
  parameter int BASE_ADDR       = 0,
  parameter int ADDR_W          = 21,
  localparam int FI_W           = $clog2(NUM_WALK_FRAMES + 2)
) (
  input  logic              frame_Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              moving,
  input  logic              jumping,
  input  logic              playerDirection,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PlayerX,
  input  logic [9:0]        PlayerY,
  output logic              playerOn,
  output logic [ADDR_W-1:0] spriteAddress,
  output logic [1:0]        animState,
  output logic [FI_W-1:0]   frameIndex
);

  localparam int FRAME_SZ = frame_sz(SPRITE_W, SPRITE_H);
  localparam int DIR_OFF  = dir_off(NUM_WALK_FRAMES, SPRITE_W, SPRITE_H, MIRROR);

  anim_state_t     state;
  logic [FI_W-1:0] frame_index;
  logic            dir;

  anim_frame_sequencer #(
    .NUM_WALK_FRAMES (NUM_WALK_FRAMES),
    .FRAME_HOLD      (FRAME_HOLD)
  ) u_seq (
    .clk         (frame_Clk),
    .reset       (Reset),
    .frame_tick  (frame_tick),
    .moving      (moving),
    .jumping     (jumping),
    .direction   (playerDirection),
    .state       (state),
    .frame_index (frame_index),
    .dir         (dir)
  );

  // 11-bit compare so a sprite near the right/bottom edge never wraps
  // around and produces hits at small coordinates.
  logic [10:0] draw_x_e, draw_y_e, player_x_e, player_y_e;
  logic        hit;
  logic [9:0]  dx, dy, col;
  logic [ADDR_W-1:0] frame_base, pix_off;

  always_comb begin
    draw_x_e   = {1'b0, DrawX};
    draw_y_e   = {1'b0, DrawY};
    player_x_e = {1'b0, PlayerX};
    player_y_e = {1'b0, PlayerY};
    hit = (draw_x_e >= player_x_e) && (draw_x_e <= player_x_e + 11'(SPRITE_W - 1)) &&
          (draw_y_e >= player_y_e) && (draw_y_e <= player_y_e + 11'(SPRITE_H - 1));
    dx  = DrawX - PlayerX;
    dy  = DrawY - PlayerY;
    col = ((MIRROR != 0) && dir) ? 10'(SPRITE_W - 1) - dx : dx;
    frame_base = ADDR_W'(BASE_ADDR) + ADDR_W'(frame_index) * ADDR_W'(FRAME_SZ) +
                 (dir ? ADDR_W'(DIR_OFF) : '0);
    pix_off    = ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      playerOn      <= 1'b0;
      spriteAddress <= ADDR_W'(BASE_ADDR);
    end else begin
      playerOn      <= hit;
      spriteAddress <= hit ? frame_base + pix_off : frame_base;
    end
  end

  assign animState  = state;
  assign frameIndex = frame_index;

endmodule
